// File: rtl/kernel3_fifo_pkg.sv
// Shared constants and helpers for the kernel3 SRL stream FIFO.
// Provides default geometry, a clog2 helper and the occupancy width.
package kernel3_fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 2;
  localparam int DEF_ADDR_WIDTH = clog2(DEF_DEPTH);
  localparam int DEF_CNT_WIDTH  = cnt_w(DEF_ADDR_WIDTH);

endpackage

// File: rtl/kernel3_fifo_srl_store.sv
// Shift-register storage: on we, din enters word 0 and word k moves to k+1.
// Ports: clk, we, addr (read select), din, dout (combinational read).
module kernel3_fifo_srl_store
  import kernel3_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        mem[k] <= mem[k-1];
      end
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/kernel3_fifo_srl_ctrl.sv
// ap_fifo stream FIFO control: occupancy, read address, registered flags.
// Ports: clk, reset_n, if_full_n/if_write_ce/if_write/if_din (write side),
//   if_empty_n/if_read_ce/if_read/if_dout (read side).
// KERNEL3_FIFO_OUTREG_EN adds a registered first-word-fall-through stage.
module kernel3_fifo_srl_ctrl
  import kernel3_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout
);

  localparam int CW = cnt_w(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_p1;
  logic [CW-1:0]         cnt_m1;
  logic                  full_n;
  logic                  srl_nempty;
  logic                  push;
  logic                  srl_pop;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] srl_dout;

  assign cnt_p1 = cnt + ONE_C;
  assign cnt_m1 = cnt - ONE_C;
  assign addr   = cnt_m1[ADDR_WIDTH-1:0];

  // Flag is registered, so a write while full is refused.
  assign push = if_write & if_write_ce & full_n;

  kernel3_fifo_srl_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_store (
    .clk (clk),
    .we  (push),
    .addr(addr),
    .din (if_din),
    .dout(srl_dout)
  );

`ifdef KERNEL3_FIFO_OUTREG_EN
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_pop;

  assign out_pop = if_read & if_read_ce & out_valid;
  // Refill the output stage from the SRL whenever it drains or is empty.
  assign srl_pop = srl_nempty & (~out_valid | out_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (srl_pop) begin
      out_valid <= 1'b1;
      out_data  <= srl_dout;
    end else if (out_pop) begin
      out_valid <= 1'b0;
    end
  end

  assign if_empty_n = out_valid;
  assign if_dout    = out_data;
`else
  assign srl_pop    = if_read & if_read_ce & srl_nempty;
  assign if_empty_n = srl_nempty;
  assign if_dout    = srl_dout;
`endif

  // Push+pop together keeps cnt; the shift moves the next word to addr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      full_n     <= 1'b1;
      srl_nempty <= 1'b0;
    end else if (push && !srl_pop) begin
      cnt        <= cnt_p1;
      srl_nempty <= 1'b1;
      full_n     <= (cnt_p1 != DEPTH_C);
    end else if (srl_pop && !push) begin
      cnt        <= cnt_m1;
      full_n     <= 1'b1;
      srl_nempty <= (cnt_m1 != '0);
    end
  end

  assign if_full_n = full_n;

endmodule

// File: doc/kernel3_fifo_srl_ctrl.md
Name: kernel3_fifo_srl_ctrl

Overview:
- Complete ap_fifo-style stream FIFO built around shift-register (SRL) storage. The write side shifts data in; this block owns the read/control end: occupancy counter, read address generation, full/empty flags and read/write handshakes.
- Instantiated between HLS kernel3 dataflow processes as the channel FIFO, default 32 bits wide and 2 deep.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- ADDR_WIDTH, 1, read-address width; DEPTH <= 2**ADDR_WIDTH.
- DEPTH, 2, number of SRL storage words, >= 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_full_n  out  1  high = a write can be accepted.
- if_write_ce  in  1  write-side clock enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_empty_n  out  1  high = if_dout holds valid data.
- if_read_ce  in  1  read-side clock enable.
- if_read  in  1  read request (pop).
- if_dout  out  DATA_WIDTH  oldest word in the FIFO.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - cnt = 0, if_empty_n = 0, if_full_n = 1.
  - Storage contents are not reset; if_dout is don't-care while if_empty_n = 0.
- Occupancy: cnt is ADDR_WIDTH+1 bits, range 0..DEPTH.
- Handshake qualification:
  - push = if_write & if_write_ce & if_full_n.
  - pop = if_read & if_read_ce & if_empty_n.
  - A write while full and a read while empty are ignored. State, storage and flags stay unchanged.
- Storage: on push, word k moves to k+1 and if_din goes to word 0.
- Read address: addr = cnt-1, truncated to ADDR_WIDTH. if_dout = word[addr], combinational from registered state.
- Per-cycle update:
  - push only: cnt+1; if_empty_n <= 1; if_full_n <= (cnt+1 != DEPTH).
  - pop only: cnt-1; if_full_n <= 1; if_empty_n <= (cnt-1 != 0).
  - push and pop together: cnt unchanged; shift occurs; flags unchanged. The next-oldest word is shifted into addr.
  - neither: hold.
- Flags are registered, never combinational from inputs. There is no combinational path from if_write/if_read to any output.
- Latency: a word pushed in cycle N is visible on if_dout with if_empty_n = 1 in cycle N+1.
- Boundaries:
  - Full (cnt = DEPTH): if_full_n = 0. A simultaneous write+read performs the pop only; the write is refused because the flag is registered.
  - Empty (cnt = 0): a simultaneous write+read performs the push only.
  - cnt never wraps in either direction.
- Reset mid-operation discards all contents immediately; the flags return to their reset values asynchronously.

Optional Feature:
- Macro KERNEL3_FIFO_OUTREG_EN.
- Defined:
  - Adds a registered output stage (first-word-fall-through): out_data and out_valid registers. Effective capacity is DEPTH+1.
  - The stage loads from the SRL when (!out_valid | pop) and cnt != 0. The load decrements cnt as an internal pop.
  - if_empty_n = out_valid; if_dout = out_data, purely registered.
  - Write-to-visible latency is 2 cycles. out_valid resets to 0.
  - if_full_n is unchanged (reflects SRL occupancy only).
- Undefined: behaviour exactly as above, with combinational SRL read and 1-cycle latency.

Decomposition:
- Package kernel3_fifo_pkg:
  - default DATA_WIDTH/ADDR_WIDTH/DEPTH localparams;
  - function clog2 for deriving ADDR_WIDTH;
  - cnt width constant.
- Sub-module kernel3_fifo_srl_store: SRL array with we/addr/din/dout. It holds no reset and no control.
- Counter, flags and the optional output stage stay in the top.

Test Plan:
- Reset: assert reset_n = 0 mid-stream with cnt = 2 -> if_empty_n = 0 and if_full_n = 1 immediately (before the next clk edge); after release, a read attempt leaves cnt at 0.
- Fill: push 0xA5A5_0001 then 0xA5A5_0002 -> if_empty_n = 1 after the first edge, if_full_n = 0 after the second. A third write of 0xDEAD_BEEF is ignored. The reads return 0x...0001 then 0x...0002, then if_empty_n = 0.
- Simultaneous at cnt = 1 (holding 0x11): push 0x22 and pop in the same cycle -> cnt stays 1, if_dout = 0x22, flags unchanged.
- Simultaneous at full (0x33, 0x44): write 0x55 and read -> only the pop occurs; if_dout = 0x44, if_full_n = 1; 0x55 is never read.
- CE gating: if_write = 1 with if_write_ce = 0 for 5 cycles -> cnt stays 0 and if_empty_n stays 0. Same check for reads with if_read_ce = 0 while full: nothing is popped.
- With KERNEL3_FIFO_OUTREG_EN: push 0x77 in cycle N -> if_empty_n = 1 in N+2. Three back-to-back pushes with no reads are all accepted (capacity 3), and the fourth is refused.
